// File: rtl/mhd_err_monitor_if.sv
// Stream/control bundle between the MHD miter side and the error-rate monitor.
// The master drives the run request and verdict stream; the slave reports results.
interface mhd_err_monitor_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic [CNT_W-1:0] max_err;
  logic             early_stop;
  logic             in_valid;
  logic             f;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             first_err_vld;
  logic [CNT_W-1:0] first_err_idx;

  modport master (
    output start, num_samples, max_err, early_stop, in_valid, f,
    input  in_ready, busy, done, pass, sample_cnt, err_cnt, first_err_vld, first_err_idx
  );

  modport slave (
    input  start, num_samples, max_err, early_stop, in_valid, f,
    output in_ready, busy, done, pass, sample_cnt, err_cnt, first_err_vld, first_err_idx
  );
endinterface

// File: rtl/mhd_err_monitor.sv
// Counts miter violations over a programmed sample budget and reports a verdict.
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting verdicts, in_ready high
// DONE  | results held until the next start
module mhd_err_monitor #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mhd_err_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_e;
  logic             r_es;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_first_vld;
  logic [CNT_W-1:0] r_first_idx;
  logic             r_pass;

  logic             w_accept_start;
  logic             w_xfer;
  logic [CNT_W-1:0] w_smp_nxt;
  logic [CNT_W-1:0] w_err_nxt;
  logic [CNT_W:0]   w_e_p1;
  logic             w_hit_n;
  logic             w_hit_e;
  logic             w_finish;

  assign w_accept_start = bus.start & (r_state != S_RUN);
  assign w_xfer         = (r_state == S_RUN) & bus.in_valid;
  assign w_smp_nxt      = r_sample_cnt + ONE;
  assign w_err_nxt      = (bus.f && !(&r_err_cnt)) ? r_err_cnt + ONE : r_err_cnt;
  // One extra bit so E = all-ones can never be reached by the saturating counter.
  assign w_e_p1         = {1'b0, r_e} + {{CNT_W{1'b0}}, 1'b1};
  assign w_hit_n        = (w_smp_nxt == r_n);
  assign w_hit_e        = r_es & bus.f & ({1'b0, w_err_nxt} == w_e_p1);
  assign w_finish       = w_xfer & (w_hit_n | w_hit_e);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        if (w_finish) w_state_nxt = S_DONE;
      end
      S_IDLE, S_DONE: begin
        if (bus.start) w_state_nxt = (bus.num_samples == '0) ? S_DONE : S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (r_state == S_RUN);
    bus.busy     = (r_state == S_RUN);
    bus.done     = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n          <= '0;
      r_e          <= '0;
      r_es         <= 1'b0;
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_first_vld  <= 1'b0;
      r_first_idx  <= '0;
      r_pass       <= 1'b0;
    end else if (w_accept_start) begin
      r_n          <= bus.num_samples;
      r_e          <= bus.max_err;
      r_es         <= bus.early_stop;
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_first_vld  <= 1'b0;
      r_first_idx  <= '0;
      r_pass       <= (bus.num_samples == '0);
    end else if (w_xfer) begin
      r_sample_cnt <= w_smp_nxt;
      r_err_cnt    <= w_err_nxt;
      if (bus.f && !r_first_vld) begin
        r_first_vld <= 1'b1;
        r_first_idx <= r_sample_cnt;
      end
      if (w_finish) r_pass <= (w_err_nxt <= r_e);
    end
  end

  assign bus.pass          = r_pass;
  assign bus.sample_cnt    = r_sample_cnt;
  assign bus.err_cnt       = r_err_cnt;
  assign bus.first_err_vld = r_first_vld;
  assign bus.first_err_idx = r_first_idx;

endmodule
